seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver; the sequential successor to the lab's fixed 3-to-8 active-low digit-select decoder.
- Cycles an active-low one-hot anode select across DIGITS digits at a programmable rate.
- Decodes each digit's 4-bit hex nibble to segments.
- Snapshots input data once per frame so the display never tears; sits between lab datapaths and the board's multiplexed LED display.

---
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment display driver.
// Walks a one-hot digit select across DIGITS digits, one slot every DIV
// cycles, and decodes each digit's hex nibble to segments. Input data is
// snapshotted at frame boundaries so a frame never shows mixed values.
module seg_scan_driver #(
  parameter int DIGITS     = 8,
  parameter int DIV        = 100000,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_done
);

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  // With a single digit the index never moves, so there is nothing to de-ghost.
  localparam bit               MULTI   = (DIGITS > 1);

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                load_pending_q;
  logic [4*DIGITS-1:0] sh_data_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic [DIGITS-1:0]   sh_blank_q;
  logic                ghost_q;
  logic                frame_done_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                tick;
  logic                wrap;
  logic                load;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                blank_sel;
  logic [DIGITS-1:0]   an_hot;
  logic                show;

  assign tick = en && (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);
  assign load = load_pending_q || !en || wrap;

  // Prescaler and digit index next-state; both freeze while disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the shadowed nibble, dp and blank of the current digit.
  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = sh_data_q[4*i +: 4];
        dp_sel    = sh_dp_q[i];
        blank_sel = sh_blank_q[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  // Output next-state: the anode stays dark for one cycle after idx moves
  // so the new segment pattern never lights the old digit.
  always_comb begin
    show  = en && !blank_sel;
    an_d  = ((show && !ghost_q) ? an_hot : '0) ^ {DIGITS{ACTIVE_LOW}};
    seg_d = (show ? hex7(nib) : 7'b0) ^ {7{ACTIVE_LOW}};
    dp_d  = (show && dp_sel) ^ ACTIVE_LOW;
  end

  // Scan state, shadow snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      sh_data_q      <= '0;
      sh_dp_q        <= '0;
      sh_blank_q     <= '0;
      ghost_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      an_q           <= {DIGITS{ACTIVE_LOW}};
      seg_q          <= {7{ACTIVE_LOW}};
      dp_q           <= ACTIVE_LOW;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= 1'b0;
      if (load) begin
        sh_data_q  <= data;
        sh_dp_q    <= dp;
        sh_blank_q <= blank;
      end
      ghost_q        <= tick && MULTI;
      frame_done_q   <= wrap;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 4-digit active-low instance with a
// short slot, plus a 1-digit active-high instance scanning every cycle.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;
  logic [1:0]  scan_idx;
  logic        frame_done;

  logic        en1;
  logic [3:0]  data1;
  logic [0:0]  dp1;
  logic [0:0]  blank1;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        dp_out1;
  logic [0:0]  scan_idx1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .dp(dp), .blank(blank),
    .an(an), .seg(seg), .dp_out(dp_out), .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  seg_scan_driver #(.DIGITS(1), .DIV(1), .ACTIVE_LOW(1'b0)) u_one (
    .clk(clk), .rst(rst), .en(en1), .data(data1), .dp(dp1), .blank(blank1),
    .an(an1), .seg(seg1), .dp_out(dp_out1), .scan_idx(scan_idx1),
    .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data = 16'h0; dp = 4'h0; blank = 4'h0;
    en1 = 1'b1; data1 = 4'h8; dp1 = 1'b0; blank1 = 1'b0;
    cyc(2);
    check("rst_an", 16'(an), 16'h000F);
    check("rst_seg", 16'(seg), 16'h007F);
    check("rst_dp", 16'(dp_out), 16'h0001);
    check("rst_idx", 16'(scan_idx), 16'h0000);
    check("rst_fd", 16'(frame_done), 16'h0000);
    check("one_rst_an", 16'(an1), 16'h0000);
    check("one_rst_seg", 16'(seg1), 16'h0000);

    rst = 1'b0; en = 1'b1; data = 16'h3210;
    cyc(1);                                   // k=1
    check("k1_an", 16'(an), 16'h000E);
    check("k1_seg", 16'(seg), 16'h0040);
    check("k1_fd", 16'(frame_done), 16'h0000);
    check("one_k1_an", 16'(an1), 16'h0001);
    check("one_k1_seg", 16'(seg1), 16'h003F);
    check("one_k1_fd", 16'(frame_done1), 16'h0001);
    cyc(1);                                   // k=2
    check("one_k2_seg", 16'(seg1), 16'h007F);
    check("one_k2_fd", 16'(frame_done1), 16'h0001);
    cyc(2);                                   // k=4
    check("k4_an", 16'(an), 16'h000E);
    check("k4_idx", 16'(scan_idx), 16'h0001);
    cyc(1);                                   // k=5
    check("k5_ghost_an", 16'(an), 16'h000F);
    check("k5_seg1", 16'(seg), 16'h0079);
    check("one_k5_an", 16'(an1), 16'h0001);
    check("one_k5_fd", 16'(frame_done1), 16'h0001);
    cyc(1);                                   // k=6
    check("k6_an", 16'(an), 16'h000D);
    check("k6_seg1", 16'(seg), 16'h0079);

    data = 16'hFEDC;
    cyc(3);                                   // k=9
    check("k9_ghost_an", 16'(an), 16'h000F);
    check("k9_seg2_old", 16'(seg), 16'h0024);
    cyc(1);                                   // k=10
    check("k10_an", 16'(an), 16'h000B);
    cyc(4);                                   // k=14
    check("k14_an", 16'(an), 16'h0007);
    check("k14_seg3_old", 16'(seg), 16'h0030);
    cyc(1);                                   // k=15
    check("k15_fd", 16'(frame_done), 16'h0000);
    cyc(1);                                   // k=16
    check("k16_fd", 16'(frame_done), 16'h0001);
    check("k16_idx", 16'(scan_idx), 16'h0000);
    cyc(1);                                   // k=17
    check("k17_fd", 16'(frame_done), 16'h0000);
    check("k17_an", 16'(an), 16'h000F);
    check("k17_segC", 16'(seg), 16'h0046);
    cyc(1);                                   // k=18
    check("k18_an", 16'(an), 16'h000E);
    check("k18_segC", 16'(seg), 16'h0046);
    cyc(12);                                  // k=30
    check("k30_an", 16'(an), 16'h0007);
    check("k30_segF", 16'(seg), 16'h000E);
    cyc(2);                                   // k=32
    check("k32_fd", 16'(frame_done), 16'h0001);

    blank = 4'b0100; dp = 4'b0001;
    cyc(18);                                  // k=50
    check("k50_an", 16'(an), 16'h000E);
    check("k50_seg", 16'(seg), 16'h0046);
    check("k50_dp", 16'(dp_out), 16'h0000);
    cyc(4);                                   // k=54
    check("k54_an", 16'(an), 16'h000D);
    check("k54_segD", 16'(seg), 16'h0021);
    check("k54_dp", 16'(dp_out), 16'h0001);
    cyc(4);                                   // k=58
    check("k58_blank_an", 16'(an), 16'h000F);
    check("k58_blank_seg", 16'(seg), 16'h007F);
    check("k58_blank_dp", 16'(dp_out), 16'h0001);
    cyc(4);                                   // k=62
    check("k62_an", 16'(an), 16'h0007);
    check("k62_dp", 16'(dp_out), 16'h0001);

    blank = 4'b0000; dp = 4'b0000;
    cyc(11);                                  // k=73: idx=2, cnt=1
    check("k73_idx", 16'(scan_idx), 16'h0002);
    en = 1'b0;
    cyc(1);                                   // k=74
    check("dis_an", 16'(an), 16'h000F);
    check("dis_seg", 16'(seg), 16'h007F);
    check("dis_dp", 16'(dp_out), 16'h0001);
    check("dis_idx", 16'(scan_idx), 16'h0002);
    cyc(9);                                   // k=83
    check("dis_hold_idx", 16'(scan_idx), 16'h0002);
    check("dis_hold_an", 16'(an), 16'h000F);
    en = 1'b1;
    cyc(1);                                   // k=84
    check("res_an", 16'(an), 16'h000B);
    check("res_segE", 16'(seg), 16'h0006);
    cyc(1);                                   // k=85
    check("res_idx2", 16'(scan_idx), 16'h0002);
    cyc(1);                                   // k=86
    check("res_idx3", 16'(scan_idx), 16'h0003);
    cyc(1);                                   // k=87
    check("res_ghost_an", 16'(an), 16'h000F);
    check("res_segF", 16'(seg), 16'h000E);
    cyc(1);                                   // k=88: idx=3, cnt=2
    check("k88_an", 16'(an), 16'h0007);

    rst = 1'b1;
    cyc(1);
    check("mrst_an", 16'(an), 16'h000F);
    check("mrst_seg", 16'(seg), 16'h007F);
    check("mrst_idx", 16'(scan_idx), 16'h0000);
    check("mrst_fd", 16'(frame_done), 16'h0000);
    check("one_mrst_fd", 16'(frame_done1), 16'h0000);
    rst = 1'b0;
    cyc(1);
    check("post_an", 16'(an), 16'h000E);
    check("post_seg", 16'(seg), 16'h0040);
    check("post_fd", 16'(frame_done), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
